dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port word memory answering one load/store request at a time with a
// valid/ready response. Define DMEM_WAIT_STATE_EN to add WAIT_CYCLES of extra latency.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef DMEM_WAIT_STATE_EN
    WAIT = 2'd1,
`endif
    RESP = 2'd2
  } stateT;

  typedef struct packed {
    logic          we;
    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } reqT;

  stateT       state;
  logic        reqReadyQ;
  logic        accept;
  logic [29:0] wordIdx;
  reqT         req;
  logic [31:0] mem [DEPTH];

`ifdef DMEM_WAIT_STATE_EN
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] waitCnt;
`endif

  assign req_ready = reqReadyQ;
  assign accept    = reqReadyQ && req_valid && !rst;
  assign wordIdx   = req_addr[31:2];

  always_comb begin
    req.we    = req_we;
    req.err   = (req_addr[1:0] != 2'b00) || (wordIdx >= 30'(DEPTH));
    req.idx   = wordIdx[AW-1:0];
    req.wdata = req_wdata;
    req.be    = req_be;
  end

  // Storage has no reset; a store commits on its acceptance edge regardless of
  // whether the response is later abandoned.
  always_ff @(posedge clk) begin
    if (accept && req.we && !req.err) begin
      for (int b = 0; b < 4; b++) begin
        if (req.be[b]) mem[req.idx][8*b +: 8] <= req.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      reqReadyQ  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
`ifdef DMEM_WAIT_STATE_EN
      waitCnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            reqReadyQ  <= 1'b0;
            resp_err   <= req.err;
            resp_rdata <= (!req.we && !req.err) ? mem[req.idx] : '0;
`ifdef DMEM_WAIT_STATE_EN
            if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state   <= WAIT;
              waitCnt <= CW'(WAIT_CYCLES);
            end
`else
            state      <= RESP;
            resp_valid <= 1'b1;
`endif
          end
        end
`ifdef DMEM_WAIT_STATE_EN
        // Counter reaching zero coincides with entering RESP, giving
        // WAIT_CYCLES+1 cycles from acceptance to resp_valid.
        WAIT: begin
          waitCnt <= waitCnt - 1'b1;
          if (waitCnt == CW'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
`endif
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            reqReadyQ  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          reqReadyQ  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
